// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder: request side (start, a, b, cin) and
// status/result side (busy, done, sum, cout).
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder {cout,sum} = a + b + cin using one full_adder, LSB first; result in WIDTH+1 cycles
// after start acceptance, done pulses for one cycle, start is ignored while busy (no queuing).
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold WIDTH itself, hence WIDTH+1 in the log.
    localparam int               CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opb_q, acc_q, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_sum, fa_cout;

    full_adder u_fa (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        opa_q   <= bus.a;
                        opb_q   <= bus.b;
                        carry_q <= bus.cin;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    opa_q   <= opa_q >> 1;
                    opb_q   <= opb_q >> 1;
                    acc_q   <= {fa_sum, acc_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    // Publish including this cycle's bit; results are otherwise held.
                    if (cnt_q == LAST) begin
                        sum_q  <= {fa_sum, acc_q[WIDTH-1:1]};
                        cout_q <= fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed spec cases plus randomized
// operations compared against an arithmetic reference model.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus ();
    serial_adder #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    endfunction

    // Drives one operation from the current cycle (cycle 0) and records cycles 0..11.
    // With disturb set, operands change after acceptance and a stray start hits cycle 3.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input bit disturb, output logic [W-1:0] s, output logic co,
                          output logic [11:0] busy_m, output logic [11:0] done_m,
                          output bit held_ok);
        logic [W-1:0] s0;
        logic         c0;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = ci;
        bus.start = 1'b1;
        s0        = bus.sum;
        c0        = bus.cout;
        s         = '0;
        co        = 1'b0;
        held_ok   = 1'b1;
        busy_m[0] = bus.busy;
        done_m[0] = bus.done;
        for (int c = 1; c < 12; c++) begin
            tick();
            if (c == 1) begin
                bus.start = 1'b0;
                if (disturb) begin
                    bus.a   = W'($urandom);
                    bus.b   = W'($urandom);
                    bus.cin = 1'($urandom);
                end
            end
            if (disturb && c == 3) begin
                bus.a     = '0;
                bus.b     = '0;
                bus.start = 1'b1;
            end
            if (disturb && c == 4) bus.start = 1'b0;
            busy_m[c] = bus.busy;
            done_m[c] = bus.done;
            if (c < 9 && (bus.sum !== s0 || bus.cout !== c0)) held_ok = 1'b0;
            if (c == 9) begin
                s  = bus.sum;
                co = bus.cout;
            end
            if (c > 9 && (bus.sum !== s || bus.cout !== co)) held_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        rst       = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum: got %h want 00", bus.sum); end
        n_cmp++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
        rst       = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic test_zero();
        logic [W-1:0] s; logic co; logic [11:0] bm, dm; bit held;
        run_op(8'h00, 8'h00, 1'b0, 1'b0, s, co, bm, dm, held);
        n_cmp++; if (s !== 8'h00) begin n_fail++; $display("FAIL zero_sum: got %h want 00", s); end
        n_cmp++; if (co !== 1'b0) begin n_fail++; $display("FAIL zero_cout: got %b want 0", co); end
        n_cmp++; if (bm !== 12'h3FE) begin n_fail++; $display("FAIL zero_busy_mask: got %h want 3fe", bm); end
        n_cmp++; if (dm !== 12'h200) begin n_fail++; $display("FAIL zero_done_mask: got %h want 200", dm); end
    endtask

    task automatic test_carry();
        logic [W-1:0] s; logic co; logic [11:0] bm, dm; bit held;
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, s, co, bm, dm, held);
        n_cmp++; if ({co, s} !== 9'h100) begin n_fail++; $display("FAIL carry1: got %h want 100", {co, s}); end
        n_cmp++; if (dm !== 12'h200) begin n_fail++; $display("FAIL carry1_done_mask: got %h want 200", dm); end
        n_cmp++; if (!held) begin n_fail++; $display("FAIL carry1_hold: got changed want held"); end
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, s, co, bm, dm, held);
        n_cmp++; if ({co, s} !== 9'h1FF) begin n_fail++; $display("FAIL carry2: got %h want 1ff", {co, s}); end
        n_cmp++; if (!held) begin n_fail++; $display("FAIL carry2_hold: got changed want held"); end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] s; logic co; logic [11:0] bm, dm; bit held;
        run_op(8'h5A, 8'h3C, 1'b1, 1'b1, s, co, bm, dm, held);
        n_cmp++; if ({co, s} !== 9'h097) begin n_fail++; $display("FAIL ignore_result: got %h want 097", {co, s}); end
        n_cmp++; if (dm !== 12'h200) begin n_fail++; $display("FAIL ignore_done_mask: got %h want 200", dm); end
        n_cmp++; if (bm !== 12'h3FE) begin n_fail++; $display("FAIL ignore_busy_mask: got %h want 3fe", bm); end
    endtask

    task automatic test_back_to_back();
        logic [30:0] dm, bm, exp_d, exp_b;
        int bad_sum;
        exp_d = '0;
        exp_b = '0;
        for (int c = 0; c < 31; c++) begin
            if (c % 10 == 9) exp_d[c] = 1'b1;
            if (c % 10 != 0) exp_b[c] = 1'b1;
        end
        bad_sum   = 0;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        for (int c = 0; c < 31; c++) begin
            if (c > 0) tick();
            dm[c] = bus.done;
            bm[c] = bus.busy;
            if (bus.done && bus.sum !== 8'h02) bad_sum++;
        end
        bus.start = 1'b0;
        n_cmp++; if (dm !== exp_d) begin n_fail++; $display("FAIL b2b_done_mask: got %h want %h", dm, exp_d); end
        n_cmp++; if (bm !== exp_b) begin n_fail++; $display("FAIL b2b_busy_mask: got %h want %h", bm, exp_b); end
        n_cmp++; if (bad_sum !== 0) begin n_fail++; $display("FAIL b2b_sum: got %0d wrong sums want 0", bad_sum); end
        tick();
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] s; logic co; logic [11:0] bm, dm; bit held;
        int stray;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.sum !== 8'h00) begin n_fail++; $display("FAIL abort_sum: got %h want 00", bus.sum); end
        n_cmp++; if (bus.cout !== 1'b0) begin n_fail++; $display("FAIL abort_cout: got %b want 0", bus.cout); end
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
            tick();
        end
        n_cmp++; if (stray !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", stray); end
        run_op(8'hAA, 8'h55, 1'b1, 1'b0, s, co, bm, dm, held);
        n_cmp++; if ({co, s} !== 9'h100) begin n_fail++; $display("FAIL abort_restart: got %h want 100", {co, s}); end
        n_cmp++; if (dm !== 12'h200) begin n_fail++; $display("FAIL abort_restart_done: got %h want 200", dm); end
    endtask

    task automatic test_random();
        logic [W-1:0] s, ra, rb; logic co, rc; logic [11:0] bm, dm; bit held, dis;
        logic [W:0] exp;
        for (int i = 0; i < 25; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rc  = 1'($urandom);
            dis = 1'($urandom);
            exp = model(ra, rb, rc);
            run_op(ra, rb, rc, dis, s, co, bm, dm, held);
            n_cmp++; if ({co, s} !== exp) begin n_fail++; $display("FAIL rand_%0d: %h+%h+%b got %h want %h", i, ra, rb, rc, {co, s}, exp); end
            n_cmp++; if (dm !== 12'h200) begin n_fail++; $display("FAIL rand_done_%0d: got %h want 200", i, dm); end
            n_cmp++; if (!held) begin n_fail++; $display("FAIL rand_hold_%0d: got changed want held", i); end
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        test_reset();
        test_zero();
        test_carry();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
